lcd_phy_8080: RTL and testbench

- Downstream stage of the LCD command player / SPI pass-through. Consumes the byte stream `phy_data`/`phy_rs`/`phy_valid`/`phy_ready` and drives an 8080-style 8-bit parallel LCD bus: `D[7:0]`, `RS`, `WR_n`, `CS_n`.
- Owns chip-select management with an idle release timeout.
- Synchronises the panel FMARK (tearing effect) pin into the single-cycle `phy_fmark_stb` used upstream.

---
 rtl/lcd_phy_8080_pkg.sv | 22 ++
 rtl/lcd_phy_8080_fmark.sv | 28 ++
 rtl/lcd_phy_8080.sv | 142 ++++++++++++++
 tb/tb_lcd_phy_8080.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_phy_8080_pkg.sv
// Shared definitions for the 8080 LCD PHY: FSM encodings, default timing and a parameter
// range helper, also used by the simulation-side LCD model.
package lcd_phy_8080_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StCsSetup = 2'b01,
    StWrLo    = 2'b10,
    StWrHi    = 2'b11
  } phy_state_e;

  localparam int unsigned DefTWrl   = 1;
  localparam int unsigned DefTWrh   = 1;
  localparam int unsigned DefCsHold = 16;
  localparam int unsigned DefCw     = 8;

  // A phase length is legal when it is at least one and its reload value (val-1) fits in cw bits.
  function automatic bit param_ok(int unsigned val, int unsigned cw);
    return (val >= 1) && (longint'(val) <= (longint'(1) << cw));
  endfunction

endpackage

// File: rtl/lcd_phy_8080_fmark.sv
// Two-flop synchroniser followed by a rising-edge detector; emits a one-cycle pulse per
// low-to-high transition of an asynchronous strobe.
module lcd_fmark_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic pulse_o
);

  logic s0_q, s1_q, prev_q, stb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q   <= 1'b0;
      s1_q   <= 1'b0;
      prev_q <= 1'b0;
      stb_q  <= 1'b0;
    end else begin
      s0_q   <= async_i;
      s1_q   <= s0_q;
      prev_q <= s1_q;
      stb_q  <= s1_q & ~prev_q;
    end
  end

  assign pulse_o = stb_q;

endmodule

// File: rtl/lcd_phy_8080.sv
// 8080-style 8-bit parallel LCD write PHY with chip-select idle release and FMARK pulse output.
module lcd_phy_8080
  import lcd_phy_8080_pkg::*;
#(
  parameter int unsigned T_WRL   = DefTWrl,
  parameter int unsigned T_WRH   = DefTWrh,
  parameter int unsigned CS_HOLD = DefCsHold,
  parameter int unsigned CW      = DefCw
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] phy_data_i,
  input  logic       phy_rs_i,
  input  logic       phy_valid_i,
  output logic       phy_ready_o,
  output logic       phy_fmark_stb_o,
  input  logic       ctl_lcd_rst_i,
  output logic       busy_o,
  output logic [7:0] lcd_d_o,
  output logic       lcd_rs_o,
  output logic       lcd_wr_n_o,
  output logic       lcd_cs_n_o,
  output logic       lcd_rst_n_o,
  input  logic       lcd_fmark_i
);

  if (!param_ok(T_WRL, CW) || !param_ok(T_WRH, CW) || !param_ok(CS_HOLD, CW)) begin : gen_bad_cfg
    $error("lcd_phy_8080: T_WRL/T_WRH/CS_HOLD must be in 1..2**CW");
  end

  localparam logic [CW-1:0] WrlLoad  = CW'(T_WRL - 1);
  localparam logic [CW-1:0] WrhLoad  = CW'(T_WRH - 1);
  localparam logic [CW-1:0] HoldLast = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] One      = CW'(1);

  phy_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_n_q, wr_n_d;
  logic          cs_n_q, cs_n_d;
  logic [7:0]    d_q, d_d;
  logic          rs_q, rs_d;
  logic          rst_n_q;
  logic          accept;
  logic          cs_release;

  assign phy_ready_o = (state_q == StIdle) | ((state_q == StWrHi) & (cnt_q == '0));
  assign busy_o      = (state_q != StIdle);
  assign accept      = phy_valid_i & phy_ready_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wr_n_q  <= 1'b1;
      cs_n_q  <= 1'b1;
      d_q     <= 8'h00;
      rs_q    <= 1'b0;
      rst_n_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_n_q  <= wr_n_d;
      cs_n_q  <= cs_n_d;
      d_q     <= d_d;
      rs_q    <= rs_d;
      rst_n_q <= ~ctl_lcd_rst_i;
    end
  end

  // In StIdle the counter doubles as the CS release timer; it only runs while CS is held.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cs_release = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = cs_n_q ? StCsSetup : StWrLo;
          cnt_d   = cs_n_q ? '0 : WrlLoad;
        end else if (!cs_n_q) begin
          if (cnt_q == HoldLast) begin
            cs_release = 1'b1;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + One;
          end
        end
      end
      StCsSetup: begin
        state_d = StWrLo;
        cnt_d   = WrlLoad;
      end
      StWrLo: begin
        if (cnt_q == '0) begin
          state_d = StWrHi;
          cnt_d   = WrhLoad;
        end else begin
          cnt_d = cnt_q - One;
        end
      end
      StWrHi: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - One;
        end else if (accept) begin
          state_d = StWrLo;
          cnt_d   = WrlLoad;
        end else begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  // Pin levels are decoded from the next state so the bus lines up with the state register.
  always_comb begin
    wr_n_d = (state_d != StWrLo);
    cs_n_d = cs_n_q;
    if (state_d != StIdle) begin
      cs_n_d = 1'b0;
    end else if (cs_release) begin
      cs_n_d = 1'b1;
    end
    d_d  = accept ? phy_data_i : d_q;
    rs_d = accept ? phy_rs_i : rs_q;
  end

  assign lcd_d_o     = d_q;
  assign lcd_rs_o    = rs_q;
  assign lcd_wr_n_o  = wr_n_q;
  assign lcd_cs_n_o  = cs_n_q;
  assign lcd_rst_n_o = rst_n_q;

  lcd_fmark_sync u_fmark_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (lcd_fmark_i),
    .pulse_o (phy_fmark_stb_o)
  );

endmodule

// File: tb/tb_lcd_phy_8080.sv
// Self-checking bench: two PHY instances (1/1 and 3/2 strobe timing) against a transaction-level
// model, a bus capture that records bytes on WR_n rising edges, and directed literal checks.
module tb_lcd_phy_8080;

  localparam int NI   = 2;
  localparam int HOLD = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data  [NI];
  logic       rs_in [NI];
  logic       valid [NI];
  logic       ctl   [NI];
  logic       fmark;
  logic       rdy   [NI];
  logic       stb   [NI];
  logic       busy  [NI];
  logic       lrs   [NI];
  logic       wrn   [NI];
  logic       csn   [NI];
  logic       rstn  [NI];
  logic [7:0] ld    [NI];

  always #5 clk = ~clk;

  lcd_phy_8080 u_dut0 (
    .clk(clk), .rst(rst), .phy_data_i(data[0]), .phy_rs_i(rs_in[0]), .phy_valid_i(valid[0]),
    .phy_ready_o(rdy[0]), .phy_fmark_stb_o(stb[0]), .ctl_lcd_rst_i(ctl[0]), .busy_o(busy[0]),
    .lcd_d_o(ld[0]), .lcd_rs_o(lrs[0]), .lcd_wr_n_o(wrn[0]), .lcd_cs_n_o(csn[0]),
    .lcd_rst_n_o(rstn[0]), .lcd_fmark_i(fmark)
  );

  lcd_phy_8080 #(.T_WRL(3), .T_WRH(2), .CS_HOLD(HOLD), .CW(8)) u_dut1 (
    .clk(clk), .rst(rst), .phy_data_i(data[1]), .phy_rs_i(rs_in[1]), .phy_valid_i(valid[1]),
    .phy_ready_o(rdy[1]), .phy_fmark_stb_o(stb[1]), .ctl_lcd_rst_i(ctl[1]), .busy_o(busy[1]),
    .lcd_d_o(ld[1]), .lcd_rs_o(lrs[1]), .lcd_wr_n_o(wrn[1]), .lcd_cs_n_o(csn[1]),
    .lcd_rst_n_o(rstn[1]), .lcd_fmark_i(fmark)
  );

  function automatic int tl(int k); return (k == 0) ? 1 : 3; endfunction
  function automatic int th(int k); return (k == 0) ? 1 : 2; endfunction

  // Model: a transfer is a window of len cycles after accept: optional CS setup cycle,
  // tl cycles with WR_n low, th cycles high, ready on its last cycle.
  bit         m_act   [NI];
  int         m_p     [NI];
  int         m_len   [NI];
  int         m_setup [NI];
  int         m_idle  [NI];
  bit         m_csn   [NI];
  logic [7:0] m_d     [NI];
  bit         m_rs    [NI];
  bit         m_rstn  [NI];
  bit         fp1, fp2, fp3, m_stb;

  function automatic bit exp_ready(int k);
    return !m_act[k] || (m_p[k] == m_len[k]);
  endfunction

  function automatic bit exp_wrn(int k);
    return !(m_act[k] && (m_p[k] > m_setup[k]) && (m_p[k] <= m_setup[k] + tl(k)));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_act[k] = 0; m_p[k] = 0; m_len[k] = 0; m_setup[k] = 0; m_idle[k] = 0;
      m_csn[k] = 1; m_d[k] = 8'h00; m_rs[k] = 0; m_rstn[k] = 0;
    end
    fp1 = 0; fp2 = 0; fp3 = 0; m_stb = 0;
  endtask

  task automatic model_step();
    bit acc;
    // FMARK: a pulse appears three edges after the first edge that samples the pin high.
    m_stb = fp2 & ~fp3;
    fp3 = fp2; fp2 = fp1; fp1 = fmark;
    for (int k = 0; k < NI; k++) begin
      acc = valid[k] && exp_ready(k);
      m_rstn[k] = !ctl[k];
      if (acc) begin
        m_setup[k] = m_csn[k] ? 1 : 0;
        m_len[k]   = m_setup[k] + tl(k) + th(k);
        m_p[k]     = 1;
        m_act[k]   = 1;
        m_csn[k]   = 0;
        m_idle[k]  = 0;
        m_d[k]     = data[k];
        m_rs[k]    = rs_in[k];
      end else if (m_act[k]) begin
        if (m_p[k] == m_len[k]) begin
          m_act[k]  = 0;
          m_idle[k] = 0;
        end else begin
          m_p[k]++;
        end
      end else if (!m_csn[k]) begin
        m_idle[k]++;
        if (m_idle[k] == HOLD) begin
          m_csn[k]  = 1;
          m_idle[k] = 0;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] @%0t: got %0h, expected %0h", name, idx, $time, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int idx);
    n_cmp++;
    n_bad++;
    $display("FAIL %s[%0d] @%0t: bound expired", name, idx, $time);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        chk("ready", k, rdy[k], exp_ready(k));
        chk("busy", k, busy[k], m_act[k]);
        chk("wr_n", k, wrn[k], exp_wrn(k));
        chk("cs_n", k, csn[k], m_csn[k]);
        chk("d", k, ld[k], m_d[k]);
        chk("rs", k, lrs[k], m_rs[k]);
        chk("rst_n", k, rstn[k], m_rstn[k]);
        chk("fmark_stb", k, stb[k], m_stb);
      end
    end
  end

  logic [8:0] capq [$];
  time        capt [$];

  initial begin
    forever begin
      @(posedge wrn[0]);
      if (!rst) begin
        capq.push_back({lrs[0], ld[0]});
        capt.push_back($time);
      end
    end
  end

  // Called at a negedge; returns at the first negedge after the accepting edge.
  task automatic send(input int k, input logic [7:0] b, input logic r);
    int  n   = 0;
    bit  acc = 0;
    valid[k] = 1'b1; data[k] = b; rs_in[k] = r;
    while (!acc && n < 100) begin
      acc = (rdy[k] === 1'b1);
      @(negedge clk);
      n++;
    end
    valid[k] = 1'b0;
    if (!acc) fail_now("send_timeout", k);
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while (busy[k] !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_now("idle_timeout", k);
  endtask

  int  pulses;
  int  wn;
  logic prdy [NI];

  initial begin
    for (int k = 0; k < NI; k++) begin
      valid[k] = 0; data[k] = 0; rs_in[k] = 0; ctl[k] = 1;
    end
    fmark = 0;
    #1 rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_wr_n", i, wrn[0], 1);
      chk("idle_cs_n", i, csn[0], 1);
      chk("idle_ready", i, rdy[0], 1);
      chk("idle_busy", i, busy[0], 0);
      chk("idle_rst_n", i, rstn[0], 0);
    end
    ctl[0] = 0; ctl[1] = 0;
    @(negedge clk);
    chk("rst_n_release", 0, rstn[0], 1);

    // Single command byte with CS released.
    send(0, 8'h2C, 1'b0);
    chk("single_n1_cs_n", 0, csn[0], 0);
    chk("single_n1_wr_n", 0, wrn[0], 1);
    @(negedge clk);
    chk("single_n2_wr_n", 0, wrn[0], 0);
    chk("single_n2_d", 0, ld[0], 8'h2C);
    chk("single_n2_rs", 0, lrs[0], 0);
    @(negedge clk);
    chk("single_n3_wr_n", 0, wrn[0], 1);
    chk("single_n3_ready", 0, rdy[0], 1);
    @(negedge clk);
    chk("single_n4_busy", 0, busy[0], 0);
    repeat (15) @(negedge clk);
    chk("cs_hold_still_low", 0, csn[0], 0);
    @(negedge clk);
    chk("cs_hold_released", 0, csn[0], 1);

    // Back-to-back burst of data bytes.
    capq.delete(); capt.delete();
    for (int i = 0; i < 16; i++) send(0, 8'(i), 1'b1);
    wait_idle(0);
    chk("burst_count", 0, capq.size(), 16);
    for (int i = 0; i < 16; i++)
      if (i < capq.size()) chk("burst_byte", i, capq[i], {1'b1, 8'(i)});
    for (int i = 1; i < 16; i++)
      if (i < capt.size()) chk("burst_gap_ns", i, 32'(capt[i] - capt[i-1]), 20);

    // Slow timing: offer a byte exactly on the CS timeout cycle.
    send(1, 8'hA5, 1'b0);
    wait_idle(1);
    repeat (15) @(negedge clk);
    chk("timeout_cycle_cs_n", 1, csn[1], 0);
    send(1, 8'h3C, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("slow_cs_n", i, csn[1], 0);
      chk("slow_wr_n", i, wrn[1], (i >= 3) ? 1 : 0);
      chk("slow_ready", i, rdy[1], (i == 4) ? 1 : 0);
      @(negedge clk);
    end
    chk("slow_after_cs_n", 1, csn[1], 0);

    // FMARK: one pulse per rising edge, none while held high.
    @(negedge clk);
    #2 fmark = 1;
    @(negedge clk); chk("fmark_e1", 0, stb[0], 0);
    @(negedge clk); chk("fmark_e2", 0, stb[0], 0);
    @(negedge clk); chk("fmark_e3", 0, stb[0], 1);
    pulses = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (stb[0] === 1'b1) pulses++;
    end
    chk("fmark_held_pulses", 0, pulses, 1);
    fmark = 0;
    repeat (10) @(negedge clk);
    #3 fmark = 1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (stb[0] === 1'b1) pulses++;
    end
    chk("fmark_repeat_pulses", 0, pulses, 1);

    // Randomised traffic on both instances, alternating dense and sparse offers.
    for (int k = 0; k < NI; k++) prdy[k] = rdy[k];
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        if (!valid[k] || prdy[k]) begin
          if (((c / 300) % 2) == 0) valid[k] = ($urandom_range(0, 3) != 0);
          else                      valid[k] = ($urandom_range(0, 24) == 0);
          data[k]  = 8'($urandom);
          rs_in[k] = 1'($urandom);
        end
        prdy[k] = rdy[k];
        if ($urandom_range(0, 49) == 0) ctl[k] = ~ctl[k];
      end
      if ($urandom_range(0, 15) == 0) fmark = ~fmark;
    end
    valid[0] = 0; valid[1] = 0; ctl[0] = 0; ctl[1] = 0;
    @(negedge clk);
    wait_idle(0);
    wait_idle(1);

    // Asynchronous reset in the middle of WR_LO; the byte is dropped.
    capq.delete();
    send(0, 8'h77, 1'b0);
    wn = 0;
    while (wrn[0] !== 1'b0 && wn < 10) begin
      @(negedge clk);
      wn++;
    end
    if (wn >= 10) fail_now("wr_lo_timeout", 0);
    #2 rst = 1;
    #1;
    chk("rst_async_wr_n", 0, wrn[0], 1);
    chk("rst_async_cs_n", 0, csn[0], 1);
    chk("rst_async_busy", 0, busy[0], 0);
    chk("rst_async_d", 0, ld[0], 8'h00);
    @(negedge clk);
    rst = 0;
    chk("rst_dropped", 0, capq.size(), 0);
    @(negedge clk);
    send(0, 8'h5A, 1'b1);
    chk("post_rst_setup_cs_n", 0, csn[0], 0);
    chk("post_rst_setup_wr_n", 0, wrn[0], 1);
    wait_idle(0);
    chk("post_rst_count", 0, capq.size(), 1);
    if (capq.size() > 0) chk("post_rst_byte", 0, capq[0], {1'b1, 8'h5A});

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog[0] @%0t: simulation did not finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
